gf2_solution_streamer: RTL and testbench
========================================

Name: gf2_solution_streamer

Overview:
Producer end of the per-machine solution stream. Takes the GF(2) RREF of the augmented button/light matrix and finds the pivot and free variables. It then enumerates every assignment of the free variables, back-substitutes the pivot variables, and emits one AXI-stream beat per solution vector, ending with a tlast beat. Sits between gf2_rref and the cheapest-solution tracker in the day-10 machine-configuration path.

Parameters:
MAX_ROWS, 16, maximum matrix rows (lights)
MAX_COLS, 17, maximum matrix columns (buttons + 1 RHS column)
DATA_WIDTH, 16, stream data width; must be >= MAX_COLS-1
MAX_ROWS_W, clog2(MAX_ROWS+1) (1 if MAX_ROWS<=1), width of rows
MAX_COLS_W, clog2(MAX_COLS+1) (1 if MAX_COLS<=1), width of cols

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
rows  in  MAX_ROWS_W  active rows, 1..MAX_ROWS
cols  in  MAX_COLS_W  active columns incl. RHS, 2..MAX_COLS
RREF  in  MAX_COLS x MAX_ROWS (unpacked rows)  matrix; bit MAX_COLS-1-j = variable j, bit MAX_COLS-cols = RHS
m_tdata  out  DATA_WIDTH  solution; bit DATA_WIDTH-1-j = x_j, unused bits 0
m_tvalid  out  1  beat valid
m_tready  in  1  consumer ready
m_tlast  out  1  final beat of enumeration
m_tuser  out  1  1 = no-solution marker beat; tdata is 0 and must be ignored
busy  out  1  high outside IDLE
ready  out  1  one-cycle pulse when the final beat handshakes

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset: state IDLE. m_tvalid, m_tlast, m_tuser, ready and busy are 0. m_tdata is 0. All internal registers are cleared.
- States: IDLE -> SCAN -> PREP -> EMIT -> IDLE.
- IDLE: on start=1, latch rows, cols and RREF into a local copy, zero the row index, clear the pivot/inconsistent flags, and go to SCAN. Inputs are not re-read after this point.
- SCAN: processes one row per cycle, for exactly rows cycles.
  - A row's pivot is its highest-order 1 among the variable bits.
  - Record the pivot-column mask and the row's pivot index.
  - A row with no variable bits set and RHS=1 sets the inconsistent flag.
- PREP, one cycle:
  - free mask = active variable columns and not pivot mask.
  - k = popcount(free mask).
  - Clear the enumeration counter (width MAX_COLS-1).
- EMIT:
  - The free variables take the counter bits in ascending column order: the lowest variable index gets counter bit 0.
  - For each pivot row r: x_pivot(r) = RHS_r XOR (XOR over free f of RREF[r][f] & x_f). Computed combinationally from the counter and registered into m_tdata.
  - m_tvalid=1 throughout EMIT.
  - m_tlast=1 when counter == 2^k - 1. k=0 gives a single beat.
  - tdata, tlast and tuser stay stable while tvalid && !tready.
  - On handshake, the counter increments and the next beat is valid on the following cycle; EMIT sustains one beat/cycle under continuous tready.
  - After the tlast handshake: ready pulses for 1 cycle, then IDLE.
- Inconsistent system: EMIT sends exactly one beat with tdata=0, tuser=1, tlast=1.
- Latency: start at edge T gives the first tvalid at T+rows+2.
- start while busy is ignored.
- A reset mid-stream drops tvalid the same cycle reset is sampled. No tlast or ready follows.

Optional Feature:
GF2_SOLUTION_STREAMER_GRAY_EN: when defined, the free variables take Gray(counter) = counter ^ (counter>>1) instead of the counter. Consecutive solutions then differ in exactly one free variable. The beat count and tlast position are unchanged. When undefined, emission is in binary-counter order.

Test Plan:
1. Defaults reduced to MAX_ROWS=4, MAX_COLS=5, DATA_WIDTH=8. rows=2, cols=4, RREF[0]=5'b10110, RREF[1]=5'b01100 -> two beats: 0x80 (tlast=0), then 0x60 (tlast=1). ready pulses once. First tvalid 4 cycles after start.
2. Identity, rows=3, cols=4, RREF={5'b10010, 5'b01000, 5'b00110} -> single beat 0xA0 with tlast=1, tuser=0.
3. Inconsistent, rows=2, cols=4, RREF[0]=5'b10000, RREF[1]=5'b00010 -> one beat tdata=0x00, tuser=1, tlast=1.
4. Backpressure on test 1: tready held low 3 cycles on each beat -> tdata/tlast stable while stalled. Exactly 2 handshakes, no duplicates or drops. A start pulse issued while busy produces no extra beats.
5. rows=1, cols=4, RREF[0]=5'b10000 (x1,x2 free) -> 4 beats. Binary order: x1x2 = 00, 10, 01, 11, i.e. 0x00, 0x40, 0x20, 0x60. With GF2_SOLUTION_STREAMER_GRAY_EN: 0x00, 0x40, 0x60, 0x20.
6. rst_n asserted after the first beat of test 5 -> the next cycle tvalid=0, busy=0, no ready. A new start then replays all 4 beats correctly.

Source files
------------

// File: rtl/gf2_solution_streamer.sv
// gf2_solution_streamer
//   Producer end of the per-machine solution stream. It takes a GF(2) RREF of
//   the augmented button/light matrix and finds the pivot and free variables.
//   It then enumerates every assignment of the free variables and
//   back-substitutes the pivot variables. One AXI-stream beat is sent per
//   solution, and the last beat carries tlast. An inconsistent system sends a
//   single beat with tuser=1 and tdata=0.
//
//   Flow: IDLE -> SCAN (one row per cycle) -> PREP (one cycle) -> EMIT -> IDLE
//
//   Optional build macro:
//     GF2_SOLUTION_STREAMER_GRAY_EN - the free variables follow Gray(counter)
//     instead of the counter, so consecutive solutions differ in one free
//     variable. The beat count and the tlast position do not change.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         one-cycle request, sampled only in IDLE
//   rows, cols    active rows (1..MAX_ROWS), active columns incl. RHS (2..MAX_COLS)
//   RREF          matrix rows; bit MAX_COLS-1-j = variable j, bit MAX_COLS-cols = RHS
//   m_tdata       solution; bit DATA_WIDTH-1-j = x_j, unused bits 0
//   m_tvalid/m_tready/m_tlast/m_tuser  AXI-stream master (tuser = no-solution)
//   busy          high outside IDLE
//   ready         one-cycle pulse in the cycle after the final beat handshakes
module gf2_solution_streamer #(
    parameter int MAX_ROWS   = 16,
    parameter int MAX_COLS   = 17,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ROWS_W = (MAX_ROWS <= 1) ? 1 : $clog2(MAX_ROWS + 1),
    parameter int MAX_COLS_W = (MAX_COLS <= 1) ? 1 : $clog2(MAX_COLS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MAX_ROWS_W-1:0] rows,
    input  logic [MAX_COLS_W-1:0] cols,
    input  logic [MAX_COLS-1:0]   RREF [MAX_ROWS],
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  busy,
    output logic                  ready
);

    localparam int NV   = MAX_COLS - 1;                           // variable count
    localparam int RI_W = (MAX_ROWS <= 1) ? 1 : $clog2(MAX_ROWS); // row index
    localparam int VI_W = (NV <= 1) ? 1 : $clog2(NV);             // variable index
    localparam int CI_W = (MAX_COLS <= 1) ? 1 : $clog2(MAX_COLS); // column bit index
    localparam int K_W  = $clog2(NV + 1);                         // free-variable count

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_PREP = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    logic [1:0]            state;
    logic [MAX_COLS-1:0]   rref_q [MAX_ROWS];
    logic [MAX_ROWS_W-1:0] rows_q;
    logic [MAX_ROWS_W-1:0] row_idx;
    logic [NV-1:0]         var_act;     // variable j is inside the active columns
    logic [CI_W-1:0]       rhs_pos;     // bit position of the RHS column
    logic [NV-1:0]         piv_mask;
    logic [MAX_ROWS-1:0]   piv_valid;
    logic [VI_W-1:0]       piv_idx [MAX_ROWS];
    logic                  incons;
    logic [NV-1:0]         free_mask;
    logic [K_W-1:0]        k;
    logic [NV-1:0]         cnt;

    // ------------------------------------------------------------------
    // Start-time decode of the column geometry
    // ------------------------------------------------------------------
    logic [NV-1:0]   var_act_c;
    logic [CI_W-1:0] rhs_pos_c;

    always_comb begin
        var_act_c = '0;
        for (int j = 0; j < NV; j++) begin
            // j < cols-1, written as j+1 < cols so that nothing underflows
            var_act_c[j] = (MAX_COLS_W'(j + 1) < cols);
        end
        rhs_pos_c = CI_W'(MAX_COLS - int'(cols));
    end

    // ------------------------------------------------------------------
    // SCAN: pivot search on the current row
    // ------------------------------------------------------------------
    logic [MAX_COLS-1:0] scan_row;
    logic [NV-1:0]       scan_vars;
    logic                scan_found;
    logic [VI_W-1:0]     scan_piv;

    always_comb begin
        scan_row   = rref_q[row_idx[RI_W-1:0]];
        scan_vars  = '0;
        scan_found = 1'b0;
        scan_piv   = '0;
        for (int j = 0; j < NV; j++) begin
            scan_vars[j] = scan_row[MAX_COLS-1-j] & var_act[j];
        end
        // Walk from the high index down so the lowest variable index (the
        // highest-order matrix bit) is the one that wins.
        for (int j = NV - 1; j >= 0; j--) begin
            if (scan_vars[j]) begin
                scan_found = 1'b1;
                scan_piv   = VI_W'(j);
            end
        end
    end

    // ------------------------------------------------------------------
    // PREP: free-variable mask and its popcount
    // ------------------------------------------------------------------
    logic [NV-1:0]  free_c;
    logic [K_W-1:0] k_c;

    always_comb begin
        free_c = var_act & ~piv_mask;
        k_c    = '0;
        for (int j = 0; j < NV; j++) begin
            k_c = k_c + K_W'(free_c[j]);
        end
    end

    // ------------------------------------------------------------------
    // EMIT: build the solution for the counter value being loaded.
    // When a beat is already held, the next beat is built from cnt+1. That
    // value lands in the output register at the handshake edge, which keeps
    // the stream at one beat per cycle.
    // ------------------------------------------------------------------
    logic [NV-1:0]         sel_cnt;
    logic [NV-1:0]         g;
    logic [NV-1:0]         g_sh;
    logic [NV-1:0]         xf;
    logic [NV-1:0]         x;
    logic [NV-1:0]         vr;
    logic [NV-1:0]         lim;
    logic [DATA_WIDTH-1:0] sol_data;
    logic                  sel_last;

    always_comb begin
        sel_cnt = m_tvalid ? (cnt + NV'(1)) : cnt;
`ifdef GF2_SOLUTION_STREAMER_GRAY_EN
        g = sel_cnt ^ (sel_cnt >> 1);
`else
        g = sel_cnt;
`endif
        // Free variables, in ascending index order, consume g from bit 0 up.
        g_sh = g;
        xf   = '0;
        for (int j = 0; j < NV; j++) begin
            if (free_mask[j]) begin
                xf[j] = g_sh[0];
                g_sh  = g_sh >> 1;
            end
        end
        // Back-substitution. xf is zero on every pivot column, so the row's
        // own pivot bit and any other pivot columns drop out of the parity.
        x  = xf;
        vr = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            if (piv_valid[r]) begin
                for (int j = 0; j < NV; j++) begin
                    vr[j] = rref_q[r][MAX_COLS-1-j] & var_act[j];
                end
                x[piv_idx[r]] = rref_q[r][rhs_pos] ^ (^(vr & xf));
            end
        end
        sol_data = '0;
        for (int j = 0; j < NV; j++) begin
            sol_data[DATA_WIDTH-1-j] = x[j];
        end
        // 2^k - 1 in NV bits. k == NV shifts every one out, giving all ones.
        lim      = ~({NV{1'b1}} << k);
        sel_last = (sel_cnt == lim);
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rows_q    <= '0;
            row_idx   <= '0;
            var_act   <= '0;
            rhs_pos   <= '0;
            piv_mask  <= '0;
            piv_valid <= '0;
            incons    <= 1'b0;
            free_mask <= '0;
            k         <= '0;
            cnt       <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
            ready     <= 1'b0;
            for (int r = 0; r < MAX_ROWS; r++) begin
                rref_q[r]  <= '0;
                piv_idx[r] <= '0;
            end
        end else begin
            ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rref_q    <= RREF;
                        rows_q    <= rows;
                        var_act   <= var_act_c;
                        rhs_pos   <= rhs_pos_c;
                        row_idx   <= '0;
                        piv_mask  <= '0;
                        piv_valid <= '0;
                        incons    <= 1'b0;
                        state     <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    piv_valid[row_idx[RI_W-1:0]] <= scan_found;
                    piv_idx[row_idx[RI_W-1:0]]   <= scan_piv;
                    if (scan_found) begin
                        piv_mask[scan_piv] <= 1'b1;
                    end else if (scan_row[rhs_pos]) begin
                        incons <= 1'b1;    // 0 = 1 row
                    end
                    row_idx <= row_idx + MAX_ROWS_W'(1);
                    if (row_idx + MAX_ROWS_W'(1) == rows_q) begin
                        state <= S_PREP;
                    end
                end

                S_PREP: begin
                    free_mask <= free_c;
                    k         <= k_c;
                    cnt       <= '0;
                    state     <= S_EMIT;
                end

                S_EMIT: begin
                    if (!m_tvalid || m_tready) begin
                        if (m_tvalid && m_tlast) begin
                            // Final beat accepted
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            m_tuser  <= 1'b0;
                            m_tdata  <= '0;
                            ready    <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            cnt      <= sel_cnt;
                            m_tvalid <= 1'b1;
                            m_tdata  <= incons ? '0 : sol_data;
                            m_tuser  <= incons;
                            m_tlast  <= incons | sel_last;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_solution_streamer.sv
module tb_gf2_solution_streamer;
    localparam int MR = 4;
    localparam int MC = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    rows = '0;
    logic [2:0]    cols = '0;
    logic [MC-1:0] rref [MR];
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          m_tuser;
    logic          busy;
    logic          ready;

    always #5 clk = ~clk;

    gf2_solution_streamer #(
        .MAX_ROWS(MR), .MAX_COLS(MC), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rows(rows), .cols(cols),
        .RREF(rref), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy), .ready(ready)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Brute force: for each free-variable assignment, in enumeration order,
    // search all 2^nv vectors for the one that satisfies every equation.
    logic [MC-1:0] cur [MR];
    logic [DW-1:0] exp_d [$];
    bit            exp_l [$];
    bit            exp_u [$];

    task automatic build_exp(input int nr, input int nc);
        int nv, pm, k, g, sol, par;
        int fl [$];
        int sols [$];
        bit bad, found, ok, hit;
        logic [DW-1:0] d;
        nv = nc - 1; pm = 0; bad = 0;
        exp_d.delete(); exp_l.delete(); exp_u.delete();
        for (int r = 0; r < nr; r++) begin
            hit = 0;
            for (int j = 0; j < nv; j++)
                if (!hit && cur[r][MC-1-j]) begin pm |= (1 << j); hit = 1; end
        end
        for (int j = 0; j < nv; j++) if (((pm >> j) & 1) == 0) fl.push_back(j);
        k = fl.size();
        for (int t = 0; t < (1 << k); t++) begin
`ifdef GF2_SOLUTION_STREAMER_GRAY_EN
            g = t ^ (t >> 1);
`else
            g = t;
`endif
            found = 0; sol = 0;
            for (int xv = 0; xv < (1 << nv); xv++) begin
                ok = 1;
                for (int i = 0; i < k; i++)
                    if (((xv >> fl[i]) & 1) != ((g >> i) & 1)) ok = 0;
                for (int r = 0; r < nr; r++) begin
                    par = 0;
                    for (int j = 0; j < nv; j++) par ^= int'(cur[r][MC-1-j]) & ((xv >> j) & 1);
                    if (par != int'(cur[r][MC-nc])) ok = 0;
                end
                if (ok) begin sol = xv; found = 1; end
            end
            if (!found) bad = 1; else sols.push_back(sol);
        end
        if (bad) begin
            exp_d.push_back('0); exp_l.push_back(1'b1); exp_u.push_back(1'b1);
        end else begin
            for (int t = 0; t < (1 << k); t++) begin
                d = '0;
                for (int j = 0; j < nv; j++) if ((sols[t] >> j) & 1) d[DW-1-j] = 1'b1;
                exp_d.push_back(d); exp_l.push_back(t == (1 << k) - 1); exp_u.push_back(1'b0);
            end
        end
    endtask

    // Random well-formed RREF, with garbage in unused bits and unused rows
    task automatic gen_rand(output int nr, output int nc);
        int nv, p, pm;
        int pc [MR];
        logic [MC-1:0] v;
        nc = $urandom_range(2, MC); nv = nc - 1; nr = $urandom_range(1, MR);
        for (int r = 0; r < MR; r++) cur[r] = MC'($urandom);
        p = 0; pm = 0;
        for (int j = 0; j < nv; j++)
            if (p < nr && $urandom_range(0, 2) != 0) begin pc[p] = j; p++; pm |= (1 << j); end
        for (int r = 0; r < nr; r++) begin
            v = MC'($urandom) & MC'((1 << (MC - nc)) - 1);
            if (r < p) begin
                v[MC-1-pc[r]] = 1'b1;
                for (int j = pc[r] + 1; j < nv; j++)
                    if (((pm >> j) & 1) == 0) v[MC-1-j] = 1'($urandom_range(0, 1));
                v[MC-nc] = 1'($urandom_range(0, 1));
            end else begin
                v[MC-nc] = ($urandom_range(0, 4) == 0);
            end
            cur[r] = v;
        end
    endtask

    // mode: 0 = always ready, 1 = random ready, 2 = 3-cycle stall per beat
    task automatic run_case(input string nm, input int nr, input int nc, input int mode, input bit inj);
        int cyc, nb, rdy_n, scnt, done_at, extra;
        bit stall_prev, tr, lat_seen;
        logic [DW-1:0] hd;
        bit hl, hu;
        build_exp(nr, nc);
        rows = 3'(nr); cols = 3'(nc); rref = cur;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        // Inputs must not be re-read once the job has started
        rows = 3'($urandom); cols = 3'($urandom);
        for (int r = 0; r < MR; r++) rref[r] = MC'($urandom);
        cyc = 0; nb = 0; rdy_n = 0; scnt = 0; done_at = -1; extra = 0;
        stall_prev = 0; lat_seen = 0; hd = '0; hl = 0; hu = 0;
        while ((done_at < 0 || cyc < done_at + 3) && cyc < 600) begin
            if (ready) rdy_n++;
            if (m_tvalid && !lat_seen) begin lat_seen = 1; chk({nm, " latency"}, cyc, nr + 2); end
            if (stall_prev) begin
                chk({nm, " stall tdata"}, m_tdata, hd);
                chk({nm, " stall tlast"}, m_tlast, hl);
                chk({nm, " stall tuser"}, m_tuser, hu);
            end
            if (inj && cyc == 2) start = 1'b1; else start = 1'b0;
            case (mode)
                0: tr = 1;
                1: tr = ($urandom_range(0, 2) != 0);
                default: if (m_tvalid && scnt < 3) begin tr = 0; scnt++; end else tr = 1;
            endcase
            m_tready = tr;
            stall_prev = m_tvalid && !tr;
            hd = m_tdata; hl = m_tlast; hu = m_tuser;
            if (m_tvalid && tr) begin
                if (nb < exp_d.size()) begin
                    chk($sformatf("%s beat%0d tdata", nm, nb), m_tdata, exp_d[nb]);
                    chk($sformatf("%s beat%0d tlast", nm, nb), m_tlast, exp_l[nb]);
                    chk($sformatf("%s beat%0d tuser", nm, nb), m_tuser, exp_u[nb]);
                    if (exp_l[nb]) done_at = cyc;
                end else extra++;
                nb++; scnt = 0;
            end
            @(posedge clk); #1; cyc++;
        end
        m_tready = 1'b0; start = 1'b0;
        chk({nm, " beat count"}, nb, exp_d.size());
        chk({nm, " extra beats"}, extra, 0);
        chk({nm, " ready pulses"}, rdy_n, 1);
        chk({nm, " busy at end"}, busy, 0);
    endtask

    task automatic reset_case();
        int cyc, bad;
        bit got;
        cur[0] = 5'b10000; cur[1] = '0; cur[2] = '0; cur[3] = '0;
        build_exp(1, 4);
        rows = 3'd1; cols = 3'd4; rref = cur;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 50) begin
            m_tready = 1'b1;
            if (m_tvalid) begin chk("t6 beat0 tdata", m_tdata, exp_d[0]); got = 1; end
            @(posedge clk); #1; cyc++;
        end
        chk("t6 first beat seen", got, 1);
        rst_n = 1'b0; m_tready = 1'b0;
        @(posedge clk); #1;
        chk("t6 rst tvalid", m_tvalid, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst ready", ready, 0);
        rst_n = 1'b1; m_tready = 1'b1;
        bad = 0;
        repeat (4) begin @(posedge clk); #1; if (ready || m_tvalid || m_tlast) bad++; end
        chk("t6 quiet after rst", bad, 0);
        m_tready = 1'b0;
        run_case("t6 replay", 1, 4, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nr, nc;
        for (int r = 0; r < MR; r++) rref[r] = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst tvalid", m_tvalid, 0);
        chk("rst tlast", m_tlast, 0);
        chk("rst tuser", m_tuser, 0);
        chk("rst tdata", m_tdata, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        cur[0] = 5'b10110; cur[1] = 5'b01100; cur[2] = '0; cur[3] = '0;
        run_case("t1", 2, 4, 0, 0);
        cur[0] = 5'b10010; cur[1] = 5'b01000; cur[2] = 5'b00110; cur[3] = '0;
        run_case("t2", 3, 4, 0, 0);
        cur[0] = 5'b10000; cur[1] = 5'b00010; cur[2] = '0; cur[3] = '0;
        run_case("t3", 2, 4, 1, 0);
        cur[0] = 5'b10110; cur[1] = 5'b01100; cur[2] = '0; cur[3] = '0;
        run_case("t4", 2, 4, 2, 1);
        cur[0] = 5'b10000; cur[1] = '0; cur[2] = '0; cur[3] = '0;
        run_case("t5", 1, 4, 0, 0);
        reset_case();

        for (int i = 0; i < 40; i++) begin
            gen_rand(nr, nc);
            run_case($sformatf("rnd%0d", i), nr, nc, $urandom_range(0, 2), i[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
